// File: rtl/pwm_cap_pkg.sv
// rtl/pwm_cap_pkg.sv - shared FSM state encoding and default window size for the PWM duty capture block
package pwm_cap_pkg;

  localparam int WIN_LOG2_DEFAULT = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARM     = 2'd1;
  localparam state_t ST_MEASURE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/pwm_cap_sync.sv
// rtl/pwm_cap_sync.sv - 2-flop synchronizer with clock enable for the PWM capture input
module pwm_cap_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resync; the enable freezes both stages together with the rest of the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else if (ena) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwm_duty_capture.sv
// rtl/pwm_duty_capture.sv - PWM duty/edge capture over a 2^WIN_LOG2 window; PWM_CAP_SYNC_EN adds an input synchronizer
import pwm_cap_pkg::*;

module pwm_duty_capture #(
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic                cont,
  input  logic                pwm_in,
  output logic [WIN_LOG2:0]   duty,
  output logic [WIN_LOG2-1:0] edges,
  output logic                no_edge,
  output logic                valid,
  output logic                busy
);

  localparam logic [WIN_LOG2-1:0] WIN_MAX = '1;

  logic                s;
  logic                s_d;
  logic                rise;
  state_t              state;
  logic [WIN_LOG2-1:0] tmo_cnt;
  logic [WIN_LOG2-1:0] win;
  logic [WIN_LOG2:0]   high_cnt;
  logic [WIN_LOG2-1:0] edge_cnt;
  logic                noedge_r;
  logic                valid_r;
  logic [WIN_LOG2:0]   high_nxt;
  logic [WIN_LOG2-1:0] edge_nxt;

`ifdef PWM_CAP_SYNC_EN
  pwm_cap_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (pwm_in),
    .q     (s)
  );
`else
  assign s = pwm_in;
`endif

  assign rise     = s & ~s_d;
  assign high_nxt = high_cnt + {{WIN_LOG2{1'b0}}, s};
  assign edge_nxt = edge_cnt + {{(WIN_LOG2-1){1'b0}}, rise};
  assign valid    = valid_r & ena;

  // One-cycle delayed sample for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d <= 1'b0;
    end else if (ena) begin
      s_d <= s;
    end
  end

  // Measurement FSM; results are loaded on the last window sample so valid shows during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      win      <= '0;
      high_cnt <= '0;
      edge_cnt <= '0;
      noedge_r <= 1'b0;
      duty     <= '0;
      edges    <= '0;
      no_edge  <= 1'b0;
      valid_r  <= 1'b0;
      busy     <= 1'b0;
    end else if (ena) begin
      valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start || cont) begin
            state   <= ST_ARM;
            tmo_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_ARM: begin
          if (rise) begin
            // The aligning edge cycle is sample 0 of the window.
            win      <= {{(WIN_LOG2-1){1'b0}}, 1'b1};
            high_cnt <= {{WIN_LOG2{1'b0}}, 1'b1};
            edge_cnt <= {{(WIN_LOG2-1){1'b0}}, 1'b1};
            noedge_r <= 1'b0;
            state    <= ST_MEASURE;
          end else if (tmo_cnt == WIN_MAX) begin
            win      <= '0;
            high_cnt <= '0;
            edge_cnt <= '0;
            noedge_r <= 1'b1;
            state    <= ST_MEASURE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_MEASURE: begin
          high_cnt <= high_nxt;
          edge_cnt <= edge_nxt;
          win      <= win + 1'b1;
          if (win == WIN_MAX) begin
            duty    <= high_nxt;
            edges   <= edge_nxt;
            no_edge <= noedge_r;
            valid_r <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (cont) begin
            state   <= ST_ARM;
            tmo_cnt <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// tb/tb_pwm_duty_capture.sv - directed self-checking bench for pwm_duty_capture
module tb_pwm_duty_capture;

`ifdef PWM_CAP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       pwm_in = 1'b0;
  logic [8:0] duty;
  logic [7:0] edges;
  logic       no_edge;
  logic       valid;
  logic       busy;

  int n_checks = 0;
  int n_errs = 0;
  int mode = 0;
  int thr = 0;
  int pcnt = 0;

  pwm_duty_capture dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (start),
    .cont    (cont),
    .pwm_in  (pwm_in),
    .duty    (duty),
    .edges   (edges),
    .no_edge (no_edge),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Stimulus waveform: 0 low, 1 high, 2 toggle, 3 reference PWM (high while pcnt < thr)
  initial begin
    forever begin
      @(negedge clk);
      pcnt = (pcnt + 1) % 256;
      case (mode)
        0: pwm_in = 1'b0;
        1: pwm_in = 1'b1;
        2: pwm_in = ~pwm_in;
        default: pwm_in = (pcnt < thr);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n, output bit got);
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      tick();
      n++;
      if (valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({duty, edges, no_edge} !== 18'd0) begin
      n_errs++;
      $display("FAIL reset_outputs: got duty=%0d edges=%0d no_edge=%0b expected all 0", duty, edges, no_edge);
    end
    n_checks++;
    if ({valid, busy} !== 2'b00) begin
      n_errs++;
      $display("FAIL reset_flags: got valid=%0b busy=%0b expected 0 0", valid, busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_aligned_pwm();
    int n;
    bit got;
    mode = 3;
    thr = 170;
    repeat (300) tick();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_errs++;
      $display("FAIL aligned_busy: got %0b expected 1", busy);
    end
    wait_valid(1200, n, got);
    n_checks++;
    if (!got) begin
      n_errs++;
      $display("FAIL aligned_valid: got no valid expected valid within 1200 cycles");
    end
    n_checks++;
    if ({duty, edges, no_edge} !== {9'd170, 8'd1, 1'b0}) begin
      n_errs++;
      $display("FAIL aligned_result: got duty=%0d edges=%0d no_edge=%0b expected 170 1 0", duty, edges, no_edge);
    end
    n_checks++;
    if (pcnt !== (255 + LAT) % 256) begin
      n_errs++;
      $display("FAIL aligned_latency: got pcnt=%0d at valid expected %0d", pcnt, (255 + LAT) % 256);
    end
    tick();
    n_checks++;
    if ({valid, busy} !== 2'b00) begin
      n_errs++;
      $display("FAIL aligned_after: got valid=%0b busy=%0b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_timeout(input int level, input logic [8:0] exp_duty);
    int n;
    bit got;
    mode = level;
    repeat (5) tick();
    pulse_start();
    wait_valid(1200, n, got);
    n_checks++;
    if (!got || n != 512) begin
      n_errs++;
      $display("FAIL timeout_latency_%0d: got valid=%0b after %0d cycles expected 1 after 512", level, got, n);
    end
    n_checks++;
    if ({duty, edges, no_edge} !== {exp_duty, 8'd0, 1'b1}) begin
      n_errs++;
      $display("FAIL timeout_result_%0d: got duty=%0d edges=%0d no_edge=%0b expected %0d 0 1", level, duty, edges, no_edge, exp_duty);
    end
    tick();
  endtask

  task automatic test_toggle();
    int n;
    bit got;
    mode = 2;
    repeat (5) tick();
    pulse_start();
    wait_valid(1200, n, got);
    n_checks++;
    if (!got || {duty, edges, no_edge} !== {9'd128, 8'd128, 1'b0}) begin
      n_errs++;
      $display("FAIL toggle_result: got valid=%0b duty=%0d edges=%0d no_edge=%0b expected 1 128 128 0", got, duty, edges, no_edge);
    end
    tick();
  endtask

  task automatic test_continuous();
    int n;
    bit got;
    mode = 3;
    thr = 64;
    repeat (10) tick();
    cont = 1'b1;
    wait_valid(1200, n, got);
    n_checks++;
    if (!got || {duty, edges, no_edge} !== {9'd64, 8'd1, 1'b0}) begin
      n_errs++;
      $display("FAIL cont_first: got valid=%0b duty=%0d edges=%0d no_edge=%0b expected 1 64 1 0", got, duty, edges, no_edge);
    end
    wait_valid(1200, n, got);
    n_checks++;
    if (!got || n < 258) begin
      n_errs++;
      $display("FAIL cont_spacing: got valid=%0b spacing=%0d expected 1 and at least 258", got, n);
    end
    n_checks++;
    if ({duty, edges, no_edge} !== {9'd64, 8'd1, 1'b0}) begin
      n_errs++;
      $display("FAIL cont_second: got duty=%0d edges=%0d no_edge=%0b expected 64 1 0", duty, edges, no_edge);
    end
    repeat (100) tick();
    cont = 1'b0;
    wait_valid(1200, n, got);
    n_checks++;
    if (!got || {duty, edges} !== {9'd64, 8'd1}) begin
      n_errs++;
      $display("FAIL cont_last: got valid=%0b duty=%0d edges=%0d expected 1 64 1", got, duty, edges);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errs++;
      $display("FAIL cont_idle: got busy=%0b expected 0", busy);
    end
    wait_valid(600, n, got);
    n_checks++;
    if (got) begin
      n_errs++;
      $display("FAIL cont_extra: got extra valid after %0d cycles expected none", n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit got;
    bit seen;
    mode = 2;
    repeat (5) tick();
    pulse_start();
    repeat (50) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_errs++;
      $display("FAIL midrst_busy_before: got %0b expected 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({duty, edges, no_edge, valid, busy} !== 20'd0) begin
      n_errs++;
      $display("FAIL midrst_async: got duty=%0d edges=%0d no_edge=%0b valid=%0b busy=%0b expected all 0", duty, edges, no_edge, valid, busy);
    end
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (valid !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errs++;
      $display("FAIL midrst_quiet: got valid or busy after reset expected none");
    end
    mode = 3;
    thr = 170;
    repeat (10) tick();
    pulse_start();
    wait_valid(1200, n, got);
    n_checks++;
    if (!got || {duty, edges, no_edge} !== {9'd170, 8'd1, 1'b0}) begin
      n_errs++;
      $display("FAIL midrst_recover: got valid=%0b duty=%0d edges=%0d no_edge=%0b expected 1 170 1 0", got, duty, edges, no_edge);
    end
    tick();
  endtask

  task automatic test_ena_freeze();
    int n;
    bit got;
    bit seen;
    mode = 1;
    repeat (5) tick();
    pulse_start();
    repeat (300) tick();
    ena = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      tick();
      if (valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen || busy !== 1'b1) begin
      n_errs++;
      $display("FAIL ena_hold: got valid_seen=%0b busy=%0b expected 0 1", seen, busy);
    end
    ena = 1'b1;
    wait_valid(1200, n, got);
    n_checks++;
    if (!got || 350 + n != 562) begin
      n_errs++;
      $display("FAIL ena_latency: got valid=%0b at %0d cycles expected 1 at 562", got, 350 + n);
    end
    n_checks++;
    if ({duty, edges, no_edge} !== {9'd256, 8'd0, 1'b1}) begin
      n_errs++;
      $display("FAIL ena_result: got duty=%0d edges=%0d no_edge=%0b expected 256 0 1", duty, edges, no_edge);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_aligned_pwm();
    test_timeout(1, 9'd256);
    test_timeout(0, 9'd0);
    test_toggle();
    test_continuous();
    test_reset_mid();
    test_ena_freeze();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
